// File: rtl/frame_writer.sv
// Frame writer: packs 16-bit pixels from a first-word-fall-through FIFO into 32-bit words
// and writes them to memory in bursts of up to BURST_WORDS words per frame capture.
module frame_writer #(
    parameter int unsigned BURST_WORDS = 16,
    parameter int unsigned FRAME_WORDS = 163840,
    parameter int unsigned ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              frame_req,
    input  logic              capture_active,
    input  logic [15:0]       in_d,
    input  logic              in_rdy,
    output logic              in_next,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_valid,
    output logic              wr_last,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              short_frame,
    output logic [19:0]       words_written
);
    localparam int unsigned IDX_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_WORDS + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACT = 3'd2;
    localparam logic [2:0] ST_FILL     = 3'd3;
    localparam logic [2:0] ST_BURST    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       buf_mem [BURST_WORDS];
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              half;

    logic [31:0]      remaining;
    logic [31:0]      limit;
    logic             buf_full;
    logic [CNT_W-1:0] flush_cnt;
    logic             last_beat;

    always_comb begin
        remaining = FRAME_WORDS - 32'(words_written);
        // The final burst of a frame is shortened to what the frame still needs.
        limit     = (remaining < BURST_WORDS) ? remaining : BURST_WORDS;
        buf_full  = (32'(cnt) == limit);
        flush_cnt = cnt + CNT_W'(half);
        last_beat = (CNT_W'(idx) == cnt - 1'b1);
    end

    assign frame_req = (state == ST_REQ);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign wr_valid  = (state == ST_BURST);
    assign wr_addr   = ptr;
    assign wr_data   = wr_valid ? buf_mem[idx] : 32'h0;
    assign wr_last   = wr_valid && last_beat;
    assign in_next   = (state == ST_FILL) && !buf_full && in_rdy;

    // Buffer storage is not reset; cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (state == ST_FILL && !buf_full) begin
            if (in_rdy) begin
                if (half) begin
                    buf_mem[cnt[IDX_W-1:0]][31:16] <= in_d;
                end else begin
                    buf_mem[cnt[IDX_W-1:0]][15:0] <= in_d;
                end
            end else if (!capture_active && half) begin
                buf_mem[cnt[IDX_W-1:0]][31:16] <= 16'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            idx           <= '0;
            half          <= 1'b0;
            short_frame   <= 1'b0;
            words_written <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr           <= base_addr;
                        words_written <= '0;
                        short_frame   <= 1'b0;
                        cnt           <= '0;
                        idx           <= '0;
                        half          <= 1'b0;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: state <= ST_WAIT_ACT;
                ST_WAIT_ACT: begin
                    if (capture_active) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (buf_full) begin
                        state <= ST_BURST;
                    end else if (in_rdy) begin
                        half <= !half;
                        if (half) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (!capture_active) begin
                        // Capture ended: pad a dangling pixel and drain what is left.
                        half <= 1'b0;
                        cnt  <= flush_cnt;
                        if (flush_cnt != '0) begin
                            short_frame <= 1'b1;
                            state       <= ST_BURST;
                        end else begin
                            short_frame <= (32'(words_written) < FRAME_WORDS);
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_BURST: begin
                    if (wr_ready) begin
                        if (last_beat) begin
                            ptr           <= ptr + ADDR_W'(cnt);
                            words_written <= words_written + 20'(cnt);
                            cnt           <= '0;
                            idx           <= '0;
                            if ((32'(words_written) + 32'(cnt) >= FRAME_WORDS) || short_frame) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_FILL;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
